// File: rtl/credit_pkg.sv
// Types and helpers shared by both ends of the credit link.
// Holds the link FSM states and the credit-counter width function.
package credit_pkg;

    typedef enum logic [1:0] {
        RESET  = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } credit_state_e;

    function automatic int credit_cw(input int max_credits);
        return $clog2(max_credits + 1);
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Sender-side credit counter: load, increment and decrement.
// Saturates at MAX_CREDITS and raises a sticky overflow flag when it does.
module credit_counter
    import credit_pkg::*;
#(
    parameter  int MAX_CREDITS = 4,
    localparam int CW          = credit_cw(MAX_CREDITS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX_CREDITS);
    localparam logic [CW-1:0] ONE   = CW'(1);

    // Simultaneous inc and dec cancel out, so a full counter can still trade one for one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && !dec) begin
            if (count == MAX_C)
                overflow <= 1'b1;
            else
                count <= count + ONE;
        end else if (dec && !inc) begin
            count <= count - ONE;
        end
    end

endmodule

// File: rtl/credit_sender.sv
// Push side of the credit link: forwards ready/valid words while credits remain.
// Also runs the sender half of the reset handshake with the receiver.
module credit_sender
    import credit_pkg::*;
#(
    parameter  int WIDTH       = 8,
    parameter  int MAX_CREDITS = 4,
    localparam int CW          = credit_cw(MAX_CREDITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CW-1:0]    credit_initial,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] push_data,
    output logic             push_valid,
    input  logic             push_credit,
    input  logic             push_receiver_in_reset,
    output logic             push_sender_in_reset,
    output logic [CW-1:0]    credit_count,
    output logic             credit_error
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX_CREDITS);

    credit_state_e state, state_nxt;
    logic          accept;
    logic          cnt_load;
    logic          cnt_inc;
    logic [CW-1:0] init_clamped;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RESET;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            RESET: begin
                cnt_load  = 1'b1;
                state_nxt = SYNC;
            end
            SYNC: begin
                cnt_inc = push_credit;
                if (!push_receiver_in_reset)
                    state_nxt = ACTIVE;
            end
            ACTIVE: begin
                cnt_inc = push_credit;
                if (push_receiver_in_reset)
                    state_nxt = RESET;
            end
            default: state_nxt = RESET;
        endcase
    end

    assign init_clamped = (credit_initial > MAX_C) ? MAX_C : credit_initial;

    // Gated by the receiver reset so no word is taken on the cycle the link drops.
    assign in_ready = (state == ACTIVE) && !push_receiver_in_reset && (credit_count != '0);
    assign accept   = in_valid && in_ready;

    credit_counter #(
        .MAX_CREDITS (MAX_CREDITS)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (init_clamped),
        .inc      (cnt_inc),
        .dec      (accept),
        .count    (credit_count),
        .overflow (credit_error)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_valid           <= 1'b0;
            push_data            <= '0;
            push_sender_in_reset <= 1'b1;
        end else begin
            push_valid           <= accept;
            push_sender_in_reset <= (state_nxt == RESET);
            if (accept)
                push_data <= in_data;
        end
    end

endmodule

// File: tb/tb_credit_sender.sv
// Scoreboard bench for credit_sender: directed link scenarios then randomized traffic.
// A credit/phase model predicts handshakes; a monitor checks pushed words and timing.
module tb_credit_sender;

    localparam int WIDTH = 8;
    localparam int MAXC  = 4;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CW-1:0]    credit_initial = 3'd2;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] push_data;
    logic             push_valid;
    logic             push_credit = 1'b0;
    logic             push_receiver_in_reset = 1'b1;
    logic             push_sender_in_reset;
    logic [CW-1:0]    credit_count;
    logic             credit_error;

    credit_sender #(.WIDTH(WIDTH), .MAX_CREDITS(MAXC)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .credit_initial         (credit_initial),
        .in_data                (in_data),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .push_data              (push_data),
        .push_valid             (push_valid),
        .push_credit            (push_credit),
        .push_receiver_in_reset (push_receiver_in_reset),
        .push_sender_in_reset   (push_sender_in_reset),
        .credit_count           (credit_count),
        .credit_error           (credit_error)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cyc;
    } exp_t;
    exp_t sb[$];

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endfunction

    // Link model: phase 0 = sender resetting, 1 = waiting for receiver, 2 = link up.
    int m_phase = 0;
    int m_cred  = 0;
    int m_err   = 0;

    task automatic tick();
        int exp_ready;
        int acc;
        @(negedge clk);
        if (rst) begin
            m_phase = 0;
            m_cred  = 0;
            m_err   = 0;
            sb.delete();
        end
        exp_ready = (m_phase == 2 && !push_receiver_in_reset && m_cred > 0) ? 1 : 0;
        chk("in_ready", int'(in_ready), exp_ready);
        chk("credit_count", int'(credit_count), m_cred);
        chk("sender_in_reset", int'(push_sender_in_reset), (m_phase == 0) ? 1 : 0);
        chk("credit_error", int'(credit_error), m_err);
        acc = (in_valid && exp_ready != 0) ? 1 : 0;
        if (acc != 0) sb.push_back('{in_data, cycle + 1});
        if (!rst) begin
            if (m_phase == 0) begin
                m_cred  = (int'(credit_initial) > MAXC) ? MAXC : int'(credit_initial);
                m_phase = 1;
            end else begin
                if (push_credit && acc == 0 && m_cred == MAXC)
                    m_err = 1;
                else
                    m_cred = m_cred + int'(push_credit) - acc;
                if (m_phase == 1 && !push_receiver_in_reset)
                    m_phase = 2;
                else if (m_phase == 2 && push_receiver_in_reset)
                    m_phase = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Every pushed word must match the oldest accepted word, exactly one cycle later.
    always @(negedge clk) begin
        if (!rst) begin
            if (push_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL push_unexpected: got data %0h expected no word (cycle %0d)",
                             push_data, cycle);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("push_data", int'(push_data), int'(e.data));
                    chk("push_cycle", cycle, e.cyc);
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cycle) begin
                total++;
                bad++;
                $display("FAIL push_missing: got no word expected data %0h (cycle %0d)",
                         sb[0].data, cycle);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        // 1: reset handshake, receiver released two cycles after sender reset drops
        #1;
        ticks(2);
        rst = 1'b0;
        ticks(2);
        push_receiver_in_reset = 1'b0;
        ticks(2);
        chk("t1_count", int'(credit_count), 2);

        // 2: two credits, producer always valid -> exactly two words
        in_valid = 1'b1;
        in_data  = 8'hA1; tick();
        in_data  = 8'hA2; tick();
        in_data  = 8'hA3; ticks(3);
        chk("t2_ready_low", int'(in_ready), 0);

        // 3: one credit returned with the producer waiting
        push_credit = 1'b1; in_data = 8'hA4; tick();
        push_credit = 1'b0; ticks(3);
        in_valid = 1'b0;

        // 4: credit and accept in the same cycle
        push_credit = 1'b1; tick();
        in_valid = 1'b1; in_data = 8'hA5; tick();
        in_valid = 1'b0; push_credit = 1'b0; ticks(2);
        chk("t4_count", int'(credit_count), 1);

        // 5: fill to MAX then one extra credit
        push_credit = 1'b1; ticks(4);
        push_credit = 1'b0; ticks(2);
        chk("t5_error", int'(credit_error), 1);

        // 6: receiver resets mid-operation with a word offered
        in_valid = 1'b1; in_data = 8'hB0;
        push_receiver_in_reset = 1'b1; ticks(3);
        push_receiver_in_reset = 1'b0; ticks(3);
        in_valid = 1'b0; ticks(2);

        // randomized traffic with occasional receiver and sender resets
        rst = 1'b1; credit_initial = 3'd7; tick();
        rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            in_valid    = ($urandom_range(99) < 60);
            in_data     = 8'($urandom);
            push_credit = ($urandom_range(99) < 35);
            if ($urandom_range(99) < 2)
                push_receiver_in_reset = !push_receiver_in_reset;
            if ($urandom_range(399) == 0) begin
                rst = 1'b1;
                credit_initial = 3'($urandom_range(7));
                tick();
                rst = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        push_credit = 1'b0;
        ticks(3);
        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
